// File: rtl/e4m3_accumulator.sv
// Sums each in_last-delimited group of E4M3 values in an exact signed fixed-point accumulator.
// The group total is rounded to E4M3 (round to nearest, ties to even) once, when the group ends.
module e4m3_accumulator #(
    parameter int ACC_W     = 24,
    parameter int MAX_TERMS = 32
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic [7:0] y,
    output logic       is_output_valid,
    input  logic       out_ready,
    output logic [1:0] out_flags,
    output logic [1:0] dbg_state
);

    // Handshake: a beat moves on a rising edge where in_valid and in_ready are both high,
    // and a result moves on an edge where is_output_valid and out_ready are both high.
    // The source of a beat or a result holds it stable until that edge.

    localparam int CNT_W = $clog2(MAX_TERMS + 1);
    localparam int LW    = $clog2(ACC_W);
    localparam int EW    = LW + 1;

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        CONVERT = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t state, state_next;

    logic signed [ACC_W-1:0] acc;
    logic [CNT_W-1:0]        count;
    logic                    nan, sat;
    logic                    accept, out_fire;

    // Decode a beat into value * 2^9 as a signed integer.
    logic [3:0]              in_exp;
    logic [2:0]              in_man;
    logic                    beat_nan;
    logic [17:0]             beat_mag;
    logic signed [ACC_W-1:0] beat_ext, beat_val;

    always_comb begin
        in_exp   = in_data[6:3];
        in_man   = in_data[2:0];
        beat_nan = (in_data[6:0] == 7'h7F);
        if (in_exp == 4'd0) beat_mag = {15'd0, in_man};
        else                beat_mag = {14'd0, 1'b1, in_man} << (in_exp - 4'd1);
        beat_ext = {{(ACC_W-18){1'b0}}, beat_mag};
        beat_val = in_data[7] ? -beat_ext : beat_ext;
    end

    // Normalize the accumulator: leading one, 4-bit significand, guard and sticky.
    logic [ACC_W-1:0] mag;
    logic [LW-1:0]    lead, shamt, norm_exp;
    logic [3:0]       norm_m4;
    logic             norm_g, norm_s;

    always_comb begin
        mag  = acc[ACC_W-1] ? ACC_W'(-acc) : ACC_W'(acc);
        lead = '0;
        for (int i = 0; i < ACC_W; i++) begin
            if (mag[i]) lead = LW'(i);
        end
        shamt    = '0;
        norm_m4  = mag[3:0];
        norm_g   = 1'b0;
        norm_s   = 1'b0;
        norm_exp = mag[3] ? LW'(1) : '0;
        if (lead > LW'(3)) begin
            shamt    = lead - LW'(3);
            norm_m4  = 4'(mag >> shamt);
            norm_g   = mag[shamt - LW'(1)];
            norm_exp = lead - LW'(2);
            for (int i = 0; i < ACC_W; i++) begin
                if ((LW'(i) < shamt - LW'(1)) && mag[i]) norm_s = 1'b1;
            end
        end
    end

    // Normalized value captured in CONVERT; rounding feeds the output register in HOLD.
    logic          n_sign, n_zero, n_g, n_s;
    logic [LW-1:0] n_exp;
    logic [3:0]    n_m4;

    logic          round_up, r_ovf, conv_sat;
    logic [4:0]    m5;
    logic [EW-1:0] r_exp;
    logic [2:0]    r_man;
    logic [7:0]    conv_y;

    always_comb begin
        round_up = n_g & (n_s | n_m4[0]);
        m5       = {1'b0, n_m4} + 5'(round_up);
        r_exp    = {1'b0, n_exp} + EW'(m5[4]);
        r_man    = m5[2:0];
        r_ovf    = (r_exp > EW'(15)) || ((r_exp == EW'(15)) && (r_man == 3'd7));
        conv_sat = 1'b0;
        if (nan) begin
            conv_y = 8'h7F;
        end else if (n_zero) begin
            conv_y = 8'h00;
        end else if (r_ovf) begin
            conv_y   = {n_sign, 7'h7E};
            conv_sat = 1'b1;
        end else begin
            conv_y = {n_sign, r_exp[3:0], r_man};
        end
    end

    assign accept   = in_valid & in_ready;
    assign out_fire = is_output_valid & out_ready;

    always_ff @(posedge clock) begin
        if (reset) state <= ACCUM;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ACCUM:   if (accept && in_last) state_next = CONVERT;
            CONVERT: state_next = HOLD;
            HOLD:    if (out_fire) state_next = ACCUM;
            default: state_next = ACCUM;
        endcase
    end

    always_comb begin
        in_ready  = !reset && (state == ACCUM);
        dbg_state = state;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc             <= '0;
            count           <= '0;
            nan             <= 1'b0;
            sat             <= 1'b0;
            y               <= 8'h00;
            out_flags       <= 2'b00;
            is_output_valid <= 1'b0;
            n_sign          <= 1'b0;
            n_zero          <= 1'b1;
            n_g             <= 1'b0;
            n_s             <= 1'b0;
            n_exp           <= '0;
            n_m4            <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        if (beat_nan) nan <= 1'b1;
                        else          acc <= acc + beat_val;
                        if (count == CNT_W'(MAX_TERMS)) sat   <= 1'b1;
                        else                            count <= count + 1'b1;
                    end
                end
                CONVERT: begin
                    n_sign <= acc[ACC_W-1];
                    n_zero <= (acc == '0);
                    n_g    <= norm_g;
                    n_s    <= norm_s;
                    n_exp  <= norm_exp;
                    n_m4   <= norm_m4;
                end
                HOLD: begin
                    if (!is_output_valid) begin
                        y               <= conv_y;
                        out_flags       <= {nan, sat | conv_sat};
                        is_output_valid <= 1'b1;
                    end else if (out_ready) begin
                        is_output_valid <= 1'b0;
                        acc             <= '0;
                        count           <= '0;
                        nan             <= 1'b0;
                        sat             <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_e4m3_accumulator.sv
// Bench for e4m3_accumulator: directed groups plus random groups, checked through an expected queue
// against a real-valued model that rounds by searching the E4M3 code grid.
module tb_e4m3_accumulator;

    localparam int MAX_TERMS = 32;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid, in_last, in_ready;
    logic [7:0] y;
    logic       is_output_valid, out_ready;
    logic [1:0] out_flags, dbg_state;

    int         tests = 0;
    int         fails = 0;
    logic [9:0] exp_q[$];
    logic [7:0] grp[$];
    logic [9:0] mon_e;
    bit         rand_ready = 1'b0;
    logic       force_ready = 1'b1;
    logic       rnd_ready = 1'b1;

    e4m3_accumulator #(.ACC_W(24), .MAX_TERMS(MAX_TERMS)) dut (
        .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .y(y), .is_output_valid(is_output_valid),
        .out_ready(out_ready), .out_flags(out_flags), .dbg_state(dbg_state)
    );

    // clock / reset / watchdog
    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    always_comb out_ready = rand_ready ? rnd_ready : force_ready;

    initial begin
        forever begin
            @(posedge clock);
            #1 rnd_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // reference model
    function automatic real pow2(input int k);
        real r = 1.0;
        if (k >= 0) repeat (k) r = r * 2.0;
        else        repeat (-k) r = r / 2.0;
        return r;
    endfunction

    function automatic real e4m3_val(input logic [7:0] c);
        real m;
        int  e = int'(c[6:3]);
        int  f = int'(c[2:0]);
        if (e == 0) m = (f / 8.0) * pow2(-6);
        else        m = (1.0 + f / 8.0) * pow2(e - 7);
        return c[7] ? -m : m;
    endfunction

    function automatic logic [9:0] model();
        real        sum = 0.0;
        real        a, d, bestd;
        logic       has_nan = 1'b0;
        logic       cnt_sat = (grp.size() > MAX_TERMS);
        logic [7:0] best = 8'h00;
        foreach (grp[i]) begin
            if (grp[i][6:0] == 7'h7F) has_nan = 1'b1;
            else                      sum = sum + e4m3_val(grp[i]);
        end
        if (has_nan) return {1'b1, cnt_sat, 8'h7F};
        a = (sum < 0.0) ? -sum : sum;
        if (a == 0.0) return {1'b0, cnt_sat, 8'h00};
        if (a > 464.0) return {1'b0, 1'b1, (sum < 0.0) ? 8'hFE : 8'h7E};
        bestd = 1.0e9;
        for (int c = 0; c < 127; c++) begin
            d = e4m3_val(8'(c)) - a;
            if (d < 0.0) d = -d;
            if (d < bestd || (d == bestd && c[0] == 1'b0)) begin
                bestd = d;
                best  = 8'(c);
            end
        end
        return {1'b0, cnt_sat, (sum < 0.0), best[6:0]};
    endfunction

    // driver tasks: every task returns 1 time unit after a rising edge
    task automatic send_beat(input logic [7:0] d, input logic l);
        int waited = 0;
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        forever begin
            @(negedge clock);
            if (in_ready) break;
            waited++;
            if (waited > 200) begin
                check("beat_accept_timeout", 32'(in_ready), 32'd1);
                break;
            end
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic run_group(input bit use_model, input logic [9:0] req, input bit gaps);
        exp_q.push_back(use_model ? model() : req);
        foreach (grp[i]) begin
            if (gaps) repeat ($urandom_range(0, 1)) begin
                @(posedge clock);
                #1;
            end
            send_beat(grp[i], (i == grp.size() - 1));
        end
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!is_output_valid && n < 50) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("wait_valid_timeout", 32'(is_output_valid), 32'd1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("drain_pending", 32'(exp_q.size()), 32'd0);
    endtask

    // scoreboard monitor
    always @(negedge clock) begin
        if (!reset && is_output_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_output: got y=%02h flags=%0b required no output", y, out_flags);
            end else begin
                mon_e = exp_q.pop_front();
                check("y", 32'(y), 32'(mon_e[7:0]));
                check("flags", 32'(out_flags), 32'(mon_e[9:8]));
            end
        end
    end

    initial begin
        logic [7:0] c;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_last  = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_in_ready", 32'(in_ready), 32'd0);
        check("reset_valid", 32'(is_output_valid), 32'd0);
        check("reset_y", 32'(y), 32'h00);
        check("reset_flags", 32'(out_flags), 32'd0);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // 2 + 4 = 6, with latency checks around the last handshake
        grp = '{8'h40, 8'h48};
        run_group(1'b0, {2'b00, 8'h4C}, 1'b0);
        check("convert_in_ready", 32'(in_ready), 32'd0);
        check("lat_k", 32'(is_output_valid), 32'd0);
        @(posedge clock); #1;
        check("lat_k1", 32'(is_output_valid), 32'd0);
        @(posedge clock); #1;
        check("lat_k2", 32'(is_output_valid), 32'd1);
        check("hold_in_ready", 32'(in_ready), 32'd0);
        @(posedge clock); #1;
        check("lat_k3_drop", 32'(is_output_valid), 32'd0);
        @(posedge clock); #1;
        check("ready_after_hs", 32'(in_ready), 32'd1);

        grp = '{8'h38, 8'hB8};  run_group(1'b0, {2'b00, 8'h00}, 1'b0);
        grp = '{8'h38, 8'h18};  run_group(1'b0, {2'b00, 8'h38}, 1'b0);
        grp = '{8'h39, 8'h18};  run_group(1'b0, {2'b00, 8'h3A}, 1'b0);
        grp = '{8'h7E, 8'h7E};  run_group(1'b0, {2'b01, 8'h7E}, 1'b0);
        grp = '{8'hC0};         run_group(1'b0, {2'b00, 8'hC0}, 1'b0);
        grp = '{8'h40, 8'h7F, 8'h40}; run_group(1'b0, {2'b10, 8'h7F}, 1'b0);
        grp = '{8'h01, 8'h01};  run_group(1'b0, {2'b00, 8'h02}, 1'b0);
        grp = '{8'h05};         run_group(1'b0, {2'b00, 8'h05}, 1'b0);
        grp.delete();
        repeat (MAX_TERMS + 1) grp.push_back(8'h38);
        run_group(1'b0, {2'b01, 8'h60}, 1'b0);
        wait_drain();

        // backpressure: result held, offered beat not consumed
        force_ready = 1'b0;
        grp = '{8'h40};
        run_group(1'b0, {2'b00, 8'h40}, 1'b0);
        wait_valid();
        in_data  = 8'h48;
        in_last  = 1'b1;
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clock);
            check("bp_y", 32'(y), 32'h40);
            check("bp_flags", 32'(out_flags), 32'd0);
            check("bp_valid", 32'(is_output_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        exp_q.push_back({2'b00, 8'h48});
        force_ready = 1'b1;
        send_beat(8'h48, 1'b1);
        wait_drain();

        // reset mid-group discards the partial sum
        send_beat(8'h40, 1'b0);
        reset = 1'b1;
        @(posedge clock); #1;
        check("rst_mid_in_ready", 32'(in_ready), 32'd0);
        reset = 1'b0;
        grp = '{8'h38};
        run_group(1'b0, {2'b00, 8'h38}, 1'b0);
        wait_drain();

        // reset during HOLD: nothing is emitted
        force_ready = 1'b0;
        send_beat(8'h48, 1'b1);
        wait_valid();
        reset = 1'b1;
        @(posedge clock); #1;
        check("rst_hold_valid", 32'(is_output_valid), 32'd0);
        check("rst_hold_y", 32'(y), 32'h00);
        reset = 1'b0;
        force_ready = 1'b1;
        @(posedge clock); #1;

        // random groups with random gaps and random out_ready
        rand_ready = 1'b1;
        repeat (60) begin
            grp.delete();
            repeat ($urandom_range(1, 8)) begin
                c = 8'($urandom_range(0, 255));
                if (c[6:0] == 7'h7F && $urandom_range(0, 3) != 0) c = c ^ 8'h01;
                grp.push_back(c);
            end
            run_group(1'b1, 10'h000, 1'b1);
        end
        wait_drain();
        rand_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/e4m3_accumulator.md
Name: e4m3_accumulator

Overview:
- Downstream consumer of float_multiplier_e4m3: accepts a stream of E4M3 products and sums each group into one E4M3 result.
- Groups are delimited by in_last. Typical use: dot-product reduction of multiplier outputs.
- Accumulation is exact, in a signed fixed-point register. There is a single rounding step, at group end.

Parameters:
- ACC_W, 24, signed accumulator width. Must be ≥ 19 + clog2(MAX_TERMS).
- MAX_TERMS, 32, maximum beats per group. Beats beyond this are still added; the sat flag is set.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_data  in  8  E4M3 operand {sign, exp[3:0], man[2:0]}, bias 7.
- in_valid  in  1  in_data is valid.
- in_last  in  1  qualifies the final beat of a group; sampled with in_data.
- in_ready  out  1  block can accept a beat.
- y  out  8  E4M3 group sum.
- is_output_valid  out  1  y and out_flags are valid.
- out_ready  in  1  downstream accepts y.
- out_flags  out  2  {nan, sat}.

Behaviour:
- Format:
  - exp≠0: value = (-1)^s · 2^(exp-7) · 1.man.
  - exp=0: subnormal, value = (-1)^s · 2^-6 · 0.man.
  - S.1111.111 is NaN. There is no infinity. Max finite is ±448 (0x7E/0xFE).
- Decode: each operand becomes a signed integer equal to value·2^9, which is exact. Magnitude is at most 229376 (18 bits).
- States: ACCUM, CONVERT, HOLD.
- Reset, synchronous and dominant over everything:
  - state=ACCUM; acc=0; nan=0; sat=0; count=0.
  - y=0x00; is_output_valid=0; out_flags=0.
  - in_ready is 0 while reset is high.
- ACCUM:
  - in_ready=1.
  - Each beat with in_valid&in_ready does acc += decoded value. Add throughput is one per cycle.
  - Beat count increments on each accepted beat. If count would exceed MAX_TERMS, sat is set.
  - A NaN beat sets nan (sticky) and its value is not added.
  - An accepted beat with in_last=1 goes to CONVERT.
- CONVERT, one cycle, in_ready=0:
  - Take sign and magnitude of acc and find the leading one.
  - Form exp/man, rounding round-to-nearest-ties-to-even on the bits below man[0].
  - Mantissa carry-out after rounding increments exp.
  - Results below 2^-6 encode as subnormal with exp=0. Rounding up from subnormal into 2^-6 gives exp=1, man=0.
  - Magnitude after rounding >448 saturates to ±448 and sets sat.
  - acc=0 gives y=0x00, always positive zero.
  - nan=1 gives y=0x7F, overriding everything else.
  - Register y and out_flags, then go to HOLD.
- HOLD:
  - is_output_valid=1, in_ready=0.
  - y and out_flags stay stable until out_ready=1.
  - On the handshake edge: clear acc, count, nan and sat; drop is_output_valid; go to ACCUM.
  - in_ready rises on the next cycle. There is no same-cycle bypass.
- Latency:
  - Last beat accepted at edge k → is_output_valid=1 after edge k+2.
  - With out_ready held high, it drops after edge k+3.
- in_last on a beat with in_valid=0 is ignored.
- A one-beat group is legal; y is that operand, and a subnormal stays a subnormal.
- Reset during CONVERT or HOLD discards the group. Nothing is emitted.
- in_valid during CONVERT or HOLD: the beat is not accepted, and the source must hold it.
- Accumulator wrap cannot occur while ACC_W meets its constraint.

Test Plan:
- Two beats, 0x40 (2) then 0x48 (4), last → y=0x4C (6), flags=00, valid exactly 2 cycles after the last handshake.
- Two beats, 0x38 (1) then 0xB8 (-1), last → y=0x00, flags=00.
- Round to nearest, ties to even:
  - 0x38 (1) + 0x18 (0.0625) → y=0x38.
  - 0x39 (1.125) + 0x18 → y=0x3A.
- Two beats, 0x7E + 0x7E → y=0x7E, sat=1. Then a second group 0xC0 alone → y=0xC0, flags=00, proving flags clear.
- NaN in the middle of a group, beats 0x40, 0x7F, 0x40 (last) → y=0x7F, nan=1. Separately, subnormals 0x01 + 0x01 → y=0x02.
- Backpressure and reset:
  - Hold out_ready=0 for 3 cycles in HOLD → y and flags stable, in_ready=0, the offered beat is not consumed.
  - Assert reset mid-group after 0x40 → the next group, 0x38 alone (last), yields y=0x38.
